cellrv32_gptmr_mc: RTL

Multi-channel general purpose timer for the CELLRV32 IO space. It provides NUM_CH independent counters of CNT_W bits, each with its own prescaler select, threshold, mode and interrupt enable. Match events are collected in a sticky write-1-to-clear pending register, and all channels share one interrupt line. The block sits on the processor IO bus and shares the global clock-generator tick vector.

---
 rtl/cellrv32_gptmr_mc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cellrv32_gptmr_mc.sv
// Multi-channel general purpose timer for the CELLRV32 IO space.
// NUM_CH counters with per-channel prescaler, threshold, mode and a shared W1C pending/IRQ.
`timescale 1ns/1ps
module cellrv32_gptmr_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  output logic        irq_o
);

  // Bus handshake: every rden_i/wren_i strobe inside the 128-byte window is
  // acknowledged exactly one cycle later (no wait states, no backpressure);
  // read data is presented in that ack cycle and is 0 otherwise.
  logic        sel;
  logic [6:0]  off;
  logic [1:0]  ch_idx;
  logic [1:0]  reg_idx;
  logic [31:0] ch_num;
  logic        ch_hit;
  logic        pend_hit;

  assign sel      = (addr_i[31:7] == BASE_ADDR[31:7]);
  assign off      = addr_i[6:0];
  assign ch_idx   = off[5:4];
  assign reg_idx  = off[3:2];
  assign ch_num   = {30'd0, ch_idx};
  assign ch_hit   = sel && !off[6] && (off[1:0] == 2'b00) && (ch_num < NUM_CH);
  assign pend_hit = sel && (off == 7'h40);

  logic [NUM_CH-1:0]            en_q, en_d;
  logic [NUM_CH-1:0][2:0]       prsc_q, prsc_d;
  logic [NUM_CH-1:0]            mode_q, mode_d;
  logic [NUM_CH-1:0]            ie_q, ie_d;
  logic [NUM_CH-1:0]            done_q, done_d;
  logic [NUM_CH-1:0][CNT_W-1:0] thres_q, thres_d;
  logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            set_pend;
  logic [NUM_CH-1:0]            clr_pend;
  logic [NUM_CH-1:0]            wr_ch;
  logic [31:0]                  rdata, rdata_q, rdata_d;
  logic                         ack_q, ack_d;
  logic                         irq_q, irq_d;

  // Per-channel counter datapath; bus writes are applied after the hardware
  // update so a COUNT/CTRL write wins over an advance in the same cycle.
  always_comb begin
    en_d     = en_q;
    prsc_d   = prsc_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    done_d   = done_q;
    thres_d  = thres_q;
    count_d  = count_q;
    tick_d   = '0;
    set_pend = '0;
    wr_ch    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick_d[c] = clkgen_i[prsc_q[c]];
      wr_ch[c]  = wren_i && ch_hit && (ch_idx == 2'(c));
      if (en_q[c] && tick_q[c] && !done_q[c]) begin
        if (count_q[c] != thres_q[c]) begin
          count_d[c] = count_q[c] + CNT_W'(1);
        end else begin
          set_pend[c] = 1'b1;
          if (mode_q[c]) count_d[c] = '0;
          else           done_d[c]  = 1'b1;
        end
      end
      if (wr_ch[c]) begin
        case (reg_idx)
          2'd0: begin
            en_d[c]   = data_i[0];
            prsc_d[c] = data_i[3:1];
            mode_d[c] = data_i[4];
            ie_d[c]   = data_i[5];
            done_d[c] = 1'b0;
          end
          2'd1: thres_d[c] = data_i[CNT_W-1:0];
          2'd2: begin
            count_d[c] = data_i[CNT_W-1:0];
            done_d[c]  = 1'b0;
          end
          default: ;
        endcase
      end
    end
    clr_pend = (wren_i && pend_hit) ? data_i[NUM_CH-1:0] : '0;
    pend_d   = (pend_q & ~clr_pend) | set_pend;
    irq_d    = |(pend_q & ie_q);
  end

  always_comb begin
    rdata = '0;
    if (pend_hit) rdata = 32'(pend_q);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit && (ch_idx == 2'(c))) begin
        case (reg_idx)
          2'd0:    rdata = {25'd0, done_q[c], ie_q[c], mode_q[c], prsc_q[c], en_q[c]};
          2'd1:    rdata = 32'(thres_q[c]);
          2'd2:    rdata = 32'(count_q[c]);
          default: rdata = '0;
        endcase
      end
    end
    rdata_d = rden_i ? rdata : '0;
    ack_d   = sel && (rden_i || wren_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q    <= '0;
      prsc_q  <= '0;
      mode_q  <= '0;
      ie_q    <= '0;
      done_q  <= '0;
      thres_q <= '0;
      count_q <= '0;
      tick_q  <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      prsc_q  <= prsc_d;
      mode_q  <= mode_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      thres_q <= thres_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
    end
  end

  assign data_o      = rdata_q;
  assign ack_o       = ack_q;
  assign irq_o       = irq_q;
  assign clkgen_en_o = |en_q;

endmodule
